// File: rtl/tpu_pkg.sv
// Shared types and widths for the TPU multiply-accumulate lane.
package tpu_pkg;

    localparam int IN_W  = 8;
    localparam int MAG_W = IN_W - 1;
    localparam int ACC_W = 17;

    typedef struct packed {
        logic             sign;
        logic [MAG_W-1:0] mag;
    } sm_operand_t;

    typedef logic signed [ACC_W-1:0] acc_t;

endpackage

// File: rtl/sm_multiplier.sv
// Combinational sign-magnitude multiplier: shift-add over partial-product rows.
module sm_multiplier
    import tpu_pkg::*;
(
    input  sm_operand_t a_i,
    input  sm_operand_t b_i,
    output acc_t        prod_o
);

    logic [2*MAG_W-1:0] rows [MAG_W];
    logic [2*MAG_W-1:0] mag;
    logic               sign;

    always_comb begin
        mag = '0;
        for (int i = 0; i < MAG_W; i++) begin
            rows[i] = b_i.mag[i] ? ({{MAG_W{1'b0}}, a_i.mag} << i) : '0;
            mag     = mag + rows[i];
        end
    end

    // A zero magnitude yields +0 regardless of sign, which absorbs 8'h80.
    assign sign   = (a_i.sign ^ b_i.sign) && (mag != '0);
    assign prod_o = sign ? -acc_t'({3'b000, mag}) : acc_t'({3'b000, mag});

endmodule

// File: rtl/tpu_mac.sv
// Two-stage sign-magnitude MAC with strobed output and sticky overflow flag.
// Define SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module tpu_mac
    import tpu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             out_HL,
    output logic             error,
    input  logic [IN_W-1:0]  input1,
    input  logic [IN_W-1:0]  input2,
    output logic [ACC_W-1:0] out
);

    acc_t prod_d, prod_q;
    acc_t acc_d, acc_q;
    acc_t sum;
    acc_t out_q;
    logic error_q;
    logic ovf;

    sm_multiplier u_mul (
        .a_i    (sm_operand_t'(input1)),
        .b_i    (sm_operand_t'(input2)),
        .prod_o (prod_d)
    );

    assign sum = acc_q + prod_q;
    assign ovf = (acc_q[ACC_W-1] == prod_q[ACC_W-1]) &&
                 (sum[ACC_W-1] != acc_q[ACC_W-1]);

`ifdef SATURATE_EN
    always_comb begin
        acc_d = sum;
        if (ovf)
            acc_d = acc_q[ACC_W-1] ? acc_t'(17'h10000) : acc_t'(17'h0FFFF);
    end
`else
    assign acc_d = sum;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            prod_q  <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            error_q <= 1'b0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
            if (out_HL)
                out_q <= acc_q;
            if (ovf)
                error_q <= 1'b1;
        end
    end

    assign out   = out_q;
    assign error = error_q;

endmodule

// File: tb/tb_tpu_mac.sv
// Directed-vector bench for tpu_mac; expected values are hand-computed.
module tb_tpu_mac;

    logic        clk;
    logic        reset;
    logic        out_HL;
    logic        error;
    logic [7:0]  input1;
    logic [7:0]  input2;
    logic [16:0] out;

    int n_vec;
    int n_bad;

    tpu_mac dut (
        .clk    (clk),
        .reset  (reset),
        .out_HL (out_HL),
        .error  (error),
        .input1 (input1),
        .input2 (input2),
        .out    (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [16:0] got,
                         input logic [16:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%05h) want %0d (0x%05h)",
                     tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mac(input logic [7:0] a, input logic [7:0] b);
        input1 = a;
        input2 = b;
        step();
        input1 = 8'h00;
        input2 = 8'h00;
        step();
    endtask

    task automatic strobe();
        out_HL = 1'b1;
        step();
        out_HL = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        n_vec  = 0;
        n_bad  = 0;
        reset  = 1'b0;
        out_HL = 1'b0;
        input1 = 8'h00;
        input2 = 8'h00;

        // 1: reset, then 13*15
        step();
        step();
        check("rst_out", out, 17'd0);
        check("rst_err", {16'd0, error}, 17'd1 - 17'd1);
        reset = 1'b1;
        mac(8'h0D, 8'h0F);
        strobe();
        check("t1_out", out, 17'd195);

        // 2: 41*47
        mac(8'h29, 8'h2F);
        strobe();
        check("t2_out", out, 17'd2122);

        // 3: -9*9
        mac(8'h89, 8'h09);
        strobe();
        check("t3_out", out, 17'd2041);
        check("t3_err", {16'd0, error}, 17'd0);

        // 4: reset with an operand pair in flight
        input1 = 8'h45;
        input2 = 8'h33;
        reset  = 1'b0;
        step();
        reset  = 1'b1;
        input1 = 8'h00;
        input2 = 8'h00;
        check("t4_rst_out", out, 17'd0);
        mac(8'h01, 8'h01);
        mac(8'h89, 8'h89);
        strobe();
        check("t4_out", out, 17'd82);
        check("t4_err", {16'd0, error}, 17'd0);

        // 5: positive overflow
        do_reset();
        input1 = 8'h7F;
        input2 = 8'h7F;
        repeat (5) step();
        input1 = 8'h00;
        input2 = 8'h00;
        step();
        strobe();
`ifdef SATURATE_EN
        check("t5_out", out, 17'h0FFFF);
`else
        check("t5_out", out, 17'(-50427));
`endif
        check("t5_err", {16'd0, error}, 17'd1);
        repeat (3) step();
        check("t5_sticky", {16'd0, error}, 17'd1);

        // 5b: negative overflow
        do_reset();
        check("t5b_rst_err", {16'd0, error}, 17'd0);
        input1 = 8'hFF;
        input2 = 8'h7F;
        repeat (5) step();
        input1 = 8'h00;
        input2 = 8'h00;
        step();
        strobe();
`ifdef SATURATE_EN
        check("t5b_out", out, 17'h10000);
`else
        check("t5b_out", out, 17'd50427);
`endif
        check("t5b_err", {16'd0, error}, 17'd1);

        // 6: out holds without strobe; negative zero adds nothing
        do_reset();
        mac(8'h01, 8'h05);
        check("t6_hold", out, 17'd0);
        mac(8'h80, 8'h7F);
        check("t6_hold2", out, 17'd0);
        strobe();
        check("t6_out", out, 17'd5);
        check("t6_err", {16'd0, error}, 17'd0);

        // strobe and new operands on the same edge: out sees old acc
        input1 = 8'h02;
        input2 = 8'h83;
        out_HL = 1'b1;
        step();
        out_HL = 1'b0;
        input1 = 8'h00;
        input2 = 8'h00;
        check("t6_same_edge", out, 17'd5);
        step();
        strobe();
        check("t6_after", out, 17'(-1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
